// File: rtl/otter_intrpt_ctrl_pkg.sv
// Shared definitions for the OTTER interrupt controller: FSM state encoding,
// CSR addresses and the trap-vector alignment helper.
package otter_intrpt_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    TAKE    = 2'd2,
    HANDLER = 2'd3
  } state_t;

  localparam logic [11:0] CSR_MIE_ADDR   = 12'h304;
  localparam logic [11:0] CSR_MTVEC_ADDR = 12'h305;
  localparam logic [11:0] CSR_MEPC_ADDR  = 12'h341;

  // Direct-mode trap base: the low two mtvec bits are the mode field.
  function automatic logic [31:0] trap_base(input logic [31:0] mtvec);
    return {mtvec[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/otter_edge_sync.sv
// Optional 2-flop synchronizer plus rising-edge detector for ext_intrpt.
// Build option: define OTTER_INTRPT_SYNC_EN to insert the synchronizer.
module otter_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

`ifdef OTTER_INTRPT_SYNC_EN
  localparam int VLD_W = 3;
  logic [1:0] sync_q;
  logic       sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], async_in};
    end
  end

  assign sample = sync_q[1];
`else
  localparam int VLD_W = 1;
  logic sample;

  assign sample = async_in;
`endif

  logic             prev_q;
  logic [VLD_W-1:0] vld_q;

  // vld_q marks when the history holds a genuine post-reset sample, so a
  // level that was already high during reset is never reported as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
      vld_q  <= '0;
    end else begin
      prev_q <= sample;
      vld_q  <= (vld_q << 1) | VLD_W'(1);
    end
  end

  assign rise = vld_q[VLD_W-1] & sample & ~prev_q;

endmodule

// File: rtl/otter_intrpt_ctrl.sv
// OTTER machine-mode external interrupt controller: edge-triggered request,
// trap insertion at instruction boundaries, mret return and missed counting.
module otter_intrpt_ctrl
  import otter_intrpt_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_intrpt,
  input  logic             instr_boundary,
  input  logic             mret,
  input  logic             csr_mie,
  input  logic [31:0]      csr_mtvec,
  input  logic [31:0]      csr_mepc,
  output logic             intrpt_taken,
  output logic             pc_redirect,
  output logic [31:0]      trap_pc,
  output logic             pending,
  output logic             in_handler,
  output logic [CNT_W-1:0] missed_cnt
);

  state_t           state_q, state_d;
  logic             latch_q, latch_d;
  logic             miss_inc;
  logic [CNT_W-1:0] missed_q;
  logic             rise;

  otter_edge_sync u_edge_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ext_intrpt),
    .rise     (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      latch_q  <= 1'b0;
      missed_q <= '0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      if (miss_inc && (missed_q != '1)) begin
        missed_q <= missed_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    latch_d  = latch_q;
    miss_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = PEND;
      end
      PEND: begin
        if (rise) miss_inc = 1'b1;
        if (csr_mie && instr_boundary) state_d = TAKE;
      end
      TAKE: begin
        state_d = HANDLER;
        if (rise) begin
          if (latch_q) miss_inc = 1'b1;
          else         latch_d  = 1'b1;
        end
      end
      HANDLER: begin
        // On return, a latched request and a fresh edge collapse into one
        // pending request; if both exist the second one is lost.
        if (mret) begin
          if (latch_q || rise) begin
            state_d  = PEND;
            latch_d  = 1'b0;
            miss_inc = latch_q & rise;
          end else begin
            state_d = IDLE;
          end
        end else if (rise) begin
          if (latch_q) miss_inc = 1'b1;
          else         latch_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by rst_n so a reset drops them without waiting for a clock.
  always_comb begin
    intrpt_taken = 1'b0;
    pc_redirect  = 1'b0;
    trap_pc      = 32'h0;
    if (rst_n) begin
      if (state_q == TAKE) begin
        intrpt_taken = 1'b1;
        pc_redirect  = 1'b1;
        trap_pc      = trap_base(csr_mtvec);
      end else if (mret) begin
        pc_redirect = 1'b1;
        trap_pc     = csr_mepc;
      end
    end
  end

  assign pending    = rst_n & (state_q == PEND);
  assign in_handler = rst_n & ((state_q == TAKE) | (state_q == HANDLER));
  assign missed_cnt = missed_q;

endmodule
